// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the EX-stage hazard/forwarding controller: forward-select
// codes, the per-stage destination tag, and the scheduler state encoding.
package hazard_fwd_ctrl_pkg;

  localparam int HZ_REG_W = 3;

  localparam logic [1:0] FWD_REGFILE    = 2'd0;
  localparam logic [1:0] FWD_EXMEM      = 2'd1;
  localparam logic [1:0] FWD_MEMWB_ALU  = 2'd2;
  localparam logic [1:0] FWD_MEMWB_LOAD = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] dst;
    logic                wb;
    logic                mem_read;
  } stage_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // A stage can supply an operand only if it holds a real, writing instruction.
  function automatic logic tag_hit(input stage_t t, input logic [HZ_REG_W-1:0] idx);
    return t.valid & t.wb & (t.dst == idx);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-side request and EX-side select bundle of the hazard/forwarding
// controller; master = pipeline/decode, slave = controller.
interface hazard_fwd_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_src;
  logic [REG_W-1:0] id_dst;
  logic             id_use_src;
  logic             id_use_dst;
  logic             id_wb;
  logic             id_mem_read;
  logic             flush;
  logic             hold;
  logic             stall;
  logic             ex_bubble;
  logic [1:0]       fwd_src_sel;
  logic [1:0]       fwd_dst_sel;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_src, id_dst, id_use_src, id_use_dst, id_wb, id_mem_read,
    output flush, hold,
    input  stall, ex_bubble, fwd_src_sel, fwd_dst_sel, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_dst, id_use_src, id_use_dst, id_wb, id_mem_read,
    input  flush, hold,
    output stall, ex_bubble, fwd_src_sel, fwd_dst_sel, stall_count
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel_cmp.sv
// Per-operand forwarding priority: youngest producer (EX) wins over MEM;
// a load in MEM selects the load-data path instead of the ALU result.
module hazard_fwd_ctrl_fwd_sel_cmp
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic                use_i,
  input  logic [HZ_REG_W-1:0] idx_i,
  input  stage_t              ex_t_i,
  input  stage_t              mem_t_i,
  output logic [1:0]          sel_o
);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (use_i) begin
      if (tag_hit(ex_t_i, idx_i)) begin
        sel_o = FWD_EXMEM;
      end else if (tag_hit(mem_t_i, idx_i)) begin
        sel_o = mem_t_i.mem_read ? FWD_MEMWB_LOAD : FWD_MEMWB_ALU;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX-stage hazard/forwarding scheduler: load-use stall sequencing plus
// registered operand selects. Optional stall counter under HAZARD_PERF_EN.
//
// state | meaning
// RUN   | normal issue; a load-use hit raises stall for one cycle
// STALL | bubble sits in EX, the load in MEM; the held consumer issues next
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_W = HZ_REG_W,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  hazard_fwd_ctrl_if.slave bus
);

  state_e      state_q;
  stage_t      ex_t_q;
  stage_t      mem_t_q;
  stage_t      ex_t_d;
  logic        ex_bubble_q;
  logic [1:0]  src_sel_q;
  logic [1:0]  dst_sel_q;
  logic [1:0]  src_sel_w;
  logic [1:0]  dst_sel_w;
  logic        lu_w;
  logic        stall_w;
  logic        issue_w;
  logic [REG_W-1:0] src_idx_w;
  logic [REG_W-1:0] dst_idx_w;

  assign src_idx_w = bus.id_src;
  assign dst_idx_w = bus.id_dst;

  // No WB tag is kept: the register file writes through, so anything older
  // than MEM is already visible to a regfile read.
  always_comb begin
    lu_w = (state_q == RUN) & bus.id_valid & ex_t_q.valid & ex_t_q.wb & ex_t_q.mem_read &
           ((bus.id_use_src & (src_idx_w == ex_t_q.dst)) |
            (bus.id_use_dst & (dst_idx_w == ex_t_q.dst)));
    stall_w = lu_w & ~bus.flush & ~bus.hold;
    issue_w = bus.id_valid & ~stall_w & ~bus.flush;
    ex_t_d  = '0;
    if (issue_w) begin
      ex_t_d.valid    = 1'b1;
      ex_t_d.dst      = dst_idx_w;
      ex_t_d.wb       = bus.id_wb;
      ex_t_d.mem_read = bus.id_mem_read;
    end
  end

  hazard_fwd_ctrl_fwd_sel_cmp u_cmp_src (
    .use_i   (bus.id_use_src),
    .idx_i   (src_idx_w),
    .ex_t_i  (ex_t_q),
    .mem_t_i (mem_t_q),
    .sel_o   (src_sel_w)
  );

  hazard_fwd_ctrl_fwd_sel_cmp u_cmp_dst (
    .use_i   (bus.id_use_dst),
    .idx_i   (dst_idx_w),
    .ex_t_i  (ex_t_q),
    .mem_t_i (mem_t_q),
    .sel_o   (dst_sel_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ex_t_q      <= '0;
      mem_t_q     <= '0;
      ex_bubble_q <= 1'b1;
      src_sel_q   <= FWD_REGFILE;
      dst_sel_q   <= FWD_REGFILE;
    end else if (!bus.hold) begin
      mem_t_q     <= ex_t_q;
      ex_t_q      <= ex_t_d;
      ex_bubble_q <= ~issue_w;
      // Bubbles carry regfile selects so a flushed/stalled slot drives nothing stale.
      src_sel_q   <= issue_w ? src_sel_w : FWD_REGFILE;
      dst_sel_q   <= issue_w ? dst_sel_w : FWD_REGFILE;
      case (state_q)
        RUN:     state_q <= stall_w ? STALL : RUN;
        STALL:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.stall       = stall_w;
  assign bus.ex_bubble   = ex_bubble_q;
  assign bus.fwd_src_sel = src_sel_q;
  assign bus.fwd_dst_sel = dst_sel_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline scheduler for the execute-stage ALU: tracks destination tags of in-flight instructions (EX, MEM, WB) and issues per-operand forwarding selects, aligned with the instruction entering EX.
- Detects load-use hazards and sequences a one-cycle stall with EX bubble insertion; handles flush and external hold.
- Sits beside decode; its outputs drive the ALU operand muxes and the PC/IF-ID hold logic.

Parameters:
- REG_W, 3, register index width (8 architectural registers, R0 is general-purpose).
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode stage holds a real instruction.
- id_src  in  REG_W  source register index.
- id_dst  in  REG_W  destination/second-operand index.
- id_use_src  in  1  instruction reads id_src.
- id_use_dst  in  1  instruction reads id_dst.
- id_wb  in  1  instruction writes id_dst.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  taken branch: squash the decode instruction.
- hold  in  1  global freeze (memory busy).
- stall  out  1  hold PC and IF/ID; inject bubble into EX.
- ex_bubble  out  1  registered; the EX instruction is a bubble.
- fwd_src_sel  out  2  registered operand-A select: 0 regfile, 1 EX/MEM result, 2 MEM/WB ALU result, 3 MEM/WB load data.
- fwd_dst_sel  out  2  registered operand-B select, same encoding.
- stall_count  out  CNT_W  stall cycles (optional feature).

Behaviour:
- Tag stages ex_t, mem_t, wb_t, each holding {valid, dst, wb, mem_read}. All invalid on reset.
- Reset values: ex_bubble=1, fwd_*_sel=0, stall=0, FSM=RUN, stall_count=0.
- FSM states: RUN and STALL.
- Load-use hazard (lu): RUN & id_valid & ex_t.valid & ex_t.wb & ex_t.mem_read & ((id_use_src & id_src==ex_t.dst) | (id_use_dst & id_dst==ex_t.dst)).
- stall = lu & !flush & !hold (combinational).
- RUN->STALL on stall; STALL->RUN unconditionally, or stays in STALL while hold. In STALL, ex_t is a bubble, so no back-to-back stall is possible.
- Every cycle with !hold:
  - wb_t<=mem_t, mem_t<=ex_t.
  - ex_t<=id fields with valid=id_valid & !stall & !flush.
  - ex_bubble<=!(that valid).
- hold=1: all state, stages, and selects frozen; stall=0.
- Forward select per operand, computed from the ID instruction against stage contents before the shift, youngest first:
  - Match ex_t (valid & wb): 1.
  - Else match mem_t (valid & wb): 3 if mem_t.mem_read, else 2.
  - Else 0.
  - Unused operand: 0.
  - Registered into fwd_*_sel in the same update as ex_t; latency one cycle, aligned with the instruction in EX.
- After a load-use stall: the load sits in mem_t when the dependent instruction advances, so the select becomes 3.
- flush has priority over stall and lu: ex_t gets a bubble, FSM goes to RUN, selects go to 0.
- A reset mid-stall returns to RUN, all stages invalid.
- Index compare is full REG_W equality. No special case for R0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_count increments on each cycle with stall=1 and saturates at all-ones. Cleared only by reset.
- Undefined: no counter register; stall_count tied to 0.

Decomposition:
- Shared package holds:
  - FWD_REGFILE=0, FWD_EXMEM=1, FWD_MEMWB_ALU=2, FWD_MEMWB_LOAD=3.
  - Stage-tag struct typedef.
  - FSM state enum (RUN, STALL).
- One natural sub-module: fwd_sel_cmp, the per-operand priority comparator, instantiated twice.

Test Plan:
- ADD R1 (wb to R1), then SUB reading src R1 → next cycle fwd_src_sel=1, stall never asserted.
- ADD R2, NOP, OR reading dst R2 → fwd_dst_sel=2 when OR is in EX.
- Load R3, then AND reading src R3 → stall=1 for exactly one cycle, ex_bubble=1 next cycle, then fwd_src_sel=3 with AND in EX.
- Load R4 followed by a reader of R4 with flush=1 that cycle → stall=0, ex_bubble=1, FSM RUN.
- Hold=1 for 3 cycles during STALL → stages and selects unchanged, stall=0; after release, one stall resolution completes correctly.
- With HAZARD_PERF_EN: 5 load-use pairs → stall_count=5. Assert rst_n=0 mid-stall → all outputs return to reset values asynchronously.
